fpmul_seq_ctrl: RTL
===================

Name: fpmul_seq_ctrl

Overview:
Multi-cycle FP32 multiplier sequencer for the systolic-array processing element.
- Accepts one operand pair over a valid/ready handshake.
- Runs exponent add with bias removal, then a 24-iteration shift-add mantissa multiply, then normalisation, then overflow/underflow saturation.
- Returns the packed result over a valid/ready handshake.
- Sits between the PE operand registers and the PE accumulator. It owns the select lines of the exponent saturation mux.

Parameters:
- EXP_W, 8: exponent field width.
- FRAC_W, 23: stored fraction width. The mantissa is FRAC_W+1 bits with the hidden 1.
- BIAS, 127: exponent bias.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  1+EXP_W+FRAC_W  operand A (sign, exponent, fraction).
- in_b  in  1+EXP_W+FRAC_W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  1+EXP_W+FRAC_W  packed product.
- out_overflow  out  1  saturated high on this result.
- out_underflow  out  1  saturated low on this result.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=0 while reset is asserted, then 1 in IDLE.
  - out_valid=0, out_result=0, out_overflow=0, out_underflow=0.
  - Internal accumulator and counter cleared.
  - Reset mid-operation discards the operation. No result is ever emitted for it.
- States: IDLE, EXP, MANT, NORM, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- IDLE: when in_valid=1, latch the operands and go to EXP (accepting edge = edge 0).
- EXP, one cycle:
  - sign = sa XOR sb.
  - e = ea + eb - BIAS, computed in EXP_W+2-bit signed.
  - If ea==0 or eb==0 (zero or denormal, flushed): result = {sign, 0...}, both flags 0, go to DONE. out_valid rises after edge 2.
  - Otherwise load multiplicand/multiplier with the hidden 1, clear the 2*(FRAC_W+1)-bit product, set cnt=0, go to MANT.
- MANT, one multiplier bit per edge:
  - Add the shifted multiplicand when the current multiplier bit is 1.
  - cnt increments each edge.
  - Leave to NORM on the edge where cnt==FRAC_W (24 iterations total).
- NORM, one cycle:
  - If product MSB (bit 47) is 1: frac = product[46:24] and e = e+1.
  - Otherwise: frac = product[45:23].
  - Truncate; no rounding.
- Saturation select, registered at the NORM→DONE edge:
  - Overflow when e >= 2^EXP_W-1: exponent = 8'hFE, frac = all ones, out_overflow=1.
  - Underflow when e <= 0: exponent = 8'h01, frac = 0, out_underflow=1.
  - Otherwise exponent = e[EXP_W-1:0].
  - Both flags are never 1 together.
  - Exponent field 8'hFF inputs are treated as ordinary values. There is no Inf/NaN handling.
- Latency: out_valid=1 after edge FRAC_W+3 (edge 26) for normal operands, and after edge 2 for the zero path.
- DONE:
  - out_result and both flags are held stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE. Outputs keep their value; only out_valid drops.
  - Throughput: one operation at a time; no overlap.
- in_valid during busy states is ignored. The operands are not sampled.

Decomposition:
- Shared package fp_pkg:
  - BIAS, EXP_W, FRAC_W.
  - EXP_SAT_MAX=8'hFE, EXP_SAT_MIN=8'h01.
  - The state enum (IDLE, EXP, MANT, NORM, DONE).
- Sub-module: instantiate the existing expaddtoresult_mux for the final exponent select. Drive its underflow/overflow selects from the NORM comparison.
- FSM, counter and shift-add datapath live in fpmul_seq_ctrl.

Test Plan:
- 0x3F800000 x 0x3F800000 -> out_result 0x3F800000, flags 0, out_valid exactly 26 edges after accept.
- 0x3FC00000 x 0x40000000 (1.5 x 2.0) -> 0x40400000. Then 0x3FC00000 x 0x3FC00000 -> 0x40100000, which exercises the normalisation shift.
- 0x7F000000 x 0x7F000000 -> 0x7F7FFFFF with out_overflow=1. Then 0x00800000 x 0x00800000 -> 0x00800000 with out_underflow=1.
- 0x80000000 x 0x40000000 -> 0x80000000 with out_valid after 2 edges.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, a new in_valid is ignored. After out_ready=1, in_ready=1 on the next cycle.
- Assert rst_n=0 asynchronously at MANT cnt=10 -> all outputs 0 immediately. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_pkg: shared FP32 field widths, saturation exponents and sequencer states |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_SAT_MAX = 8'hFE;
    localparam logic [EXP_W-1:0] EXP_SAT_MIN = 8'h01;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXP  = 3'd1,
        MANT = 3'd2,
        NORM = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/expaddtoresult_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | expaddtoresult_mux: final exponent select between normal and saturated     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module expaddtoresult_mux
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0] i_exp,
    input  logic             i_sel_ovf,
    input  logic             i_sel_unf,
    output logic [EXP_W-1:0] o_exp
);

    always_comb begin
        o_exp = i_exp;
        if (i_sel_ovf) begin
            o_exp = EXP_SAT_MAX;
        end else if (i_sel_unf) begin
            o_exp = EXP_SAT_MIN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpmul_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpmul_seq_ctrl: multi-cycle FP32 shift-add multiplier with saturation      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fpmul_seq_ctrl
    import fp_pkg::*;
#(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W,
    parameter int BIAS   = fp_pkg::BIAS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   in_a,
    input  logic [EXP_W+FRAC_W:0]   in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_overflow,
    output logic                    out_underflow
);

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int MW = FRAC_W + 1;
    localparam int PW = 2 * MW;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MW);

    localparam logic [CW-1:0]        c_cnt_last = CW'(FRAC_W);
    localparam logic signed [EW-1:0] c_e_max    = EW'((1 << EXP_W) - 1);

    state_t                r_state;
    logic [W-1:0]          r_a, r_b;
    logic                  r_sign, r_zero;
    logic signed [EW-1:0]  r_e;
    logic [PW-1:0]         r_mcand, r_prod;
    logic [MW-1:0]         r_mplier;
    logic [CW-1:0]         r_cnt;
    logic                  r_in_ready, r_out_valid, r_ovf, r_unf;
    logic [W-1:0]          r_out_result;

    logic [EXP_W-1:0]      w_ea, w_eb, w_exp_sel;
    logic signed [EW-1:0]  w_e_sum, w_e_norm;
    logic                  w_norm_hi, w_ovf, w_unf;
    logic [FRAC_W-1:0]     w_frac_norm, w_frac_sat;

    assign w_ea     = r_a[W-2 -: EXP_W];
    assign w_eb     = r_b[W-2 -: EXP_W];
    assign w_e_sum  = EW'({2'b00, w_ea}) + EW'({2'b00, w_eb}) - EW'(BIAS);

    // A set product MSB means the mantissa product landed in [2,4): shift one more.
    assign w_norm_hi   = r_prod[PW-1];
    assign w_e_norm    = r_e + EW'({{(EW-1){1'b0}}, w_norm_hi});
    assign w_frac_norm = w_norm_hi ? r_prod[PW-2 -: FRAC_W] : r_prod[PW-3 -: FRAC_W];
    assign w_ovf       = (w_e_norm >= c_e_max);
    assign w_unf       = !w_ovf && (w_e_norm[EW-1] || (w_e_norm == '0));
    assign w_frac_sat  = w_ovf ? '1 : (w_unf ? '0 : w_frac_norm);

    expaddtoresult_mux u_exp_mux (
        .i_exp     (w_e_norm[EXP_W-1:0]),
        .i_sel_ovf (w_ovf),
        .i_sel_unf (w_unf),
        .o_exp     (w_exp_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_sign       <= 1'b0;
            r_zero       <= 1'b0;
            r_e          <= '0;
            r_mcand      <= '0;
            r_prod       <= '0;
            r_mplier     <= '0;
            r_cnt        <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_in_ready && in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_in_ready <= 1'b0;
                        r_state    <= EXP;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                EXP: begin
                    r_sign   <= r_a[W-1] ^ r_b[W-1];
                    r_e      <= w_e_sum;
                    r_zero   <= (w_ea == '0) || (w_eb == '0);
                    r_mcand  <= {{MW{1'b0}}, 1'b1, r_a[FRAC_W-1:0]};
                    r_mplier <= {1'b1, r_b[FRAC_W-1:0]};
                    r_prod   <= '0;
                    r_cnt    <= '0;
                    // Flushed operands skip the multiply but still pass NORM, giving a two-edge result.
                    r_state  <= ((w_ea == '0) || (w_eb == '0)) ? NORM : MANT;
                end
                MANT: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    if (r_zero) begin
                        r_out_result <= {r_sign, {(W-1){1'b0}}};
                        r_ovf        <= 1'b0;
                        r_unf        <= 1'b0;
                    end else begin
                        r_out_result <= {r_sign, w_exp_sel, w_frac_sat};
                        r_ovf        <= w_ovf;
                        r_unf        <= w_unf;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign out_overflow  = r_ovf;
    assign out_underflow = r_unf;

endmodule
`default_nettype wire
